// File: rtl/hs4_pkg.sv
// Shared types and helpers for the four-phase channel arbiter.
// Holds the FSM state encoding and the round-robin winner search.
// Combinational helpers only; no state or flow control here.
package hs4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_HI,
        REQ_LO,
        DONE,
        RECOVER
    } state_t;

    localparam int MAX_REQ   = 16;
    localparam int N_REQ_DEF = 4;
    localparam int IDX_W     = $clog2(N_REQ_DEF);

    // First set bit at or after ptr, wrapping at n. Returns ptr when nothing is set.
    // The descending scan lets the smallest offset overwrite the result last.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
        int j;
        rr_pick = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (req[j]) begin
                    rr_pick = j;
                end
            end
        end
    endfunction

endpackage

// File: rtl/hs4_channel_arbiter_sync_ff.sv
// Multi-stage synchroniser for one asynchronous level.
// Latency: STAGES clock edges from d to q.
// No flow control; samples every cycle.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] pipe;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pipe <= '0;
        end else begin
            pipe <= {pipe[STAGES-2:0], d};
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/hs4_channel_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack channel among N_REQ clocked requesters.
// Latency: grant edge + SYNC_STAGES per ack transition + one DONE cycle.
// Requesters hold req_i until done_o/err_o; a watchdog aborts a stalled handshake.
module hs4_channel_arbiter
    import hs4_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [N_REQ-1:0]           req_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [N_REQ-1:0]           done_o,
    output logic                       err_o,
    output logic [$clog2(N_REQ)-1:0]   err_id_o,
    output logic                       hs_req,
    input  logic                       hs_ack,
    output logic                       busy_o
);

    localparam int PTR_W = $clog2(N_REQ);

    logic                   ack_s;
    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_nxt;
    logic [PTR_W-1:0]       pick_idx;
    logic [TO_W-1:0]        wd_q, wd_d;
    logic                   hs_req_q, hs_req_d;
    logic [N_REQ-1:0]       gnt_q, gnt_d;
    logic [N_REQ-1:0]       done_q, done_d;
    logic                   err_q, err_d;
    logic [PTR_W-1:0]       err_id_q, err_id_d;
    logic [SYNC_STAGES-1:0] warm_q;
    logic [MAX_REQ-1:0]     req_ext;
    logic                   wd_hit;
    logic                   abort;

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (hs_ack),
        .q    (ack_s)
    );

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req_i;
        pick_idx             = PTR_W'(rr_pick(req_ext, int'(ptr_q), N_REQ));
        owner_nxt            = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        wd_hit               = (wd_q >= TO_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        wd_d     = '0;
        hs_req_d = hs_req_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        err_id_d = err_id_q;
        abort    = 1'b0;

        case (state_q)
            IDLE: begin
                // After reset, ack_s only reflects the real ack once the synchroniser has refilled.
                if ((|req_i) && !ack_s && warm_q[SYNC_STAGES-1]) begin
                    owner_d         = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    hs_req_d        = 1'b1;
                    state_d         = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    hs_req_d = 1'b0;
                    state_d  = REQ_LO;
                end else if (wd_hit) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_d         = DONE;
                    gnt_d           = '0;
                    done_d[owner_q] = 1'b1;
                    ptr_d           = owner_nxt;
                end else if (wd_hit) begin
                    abort = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            RECOVER: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                hs_req_d = 1'b0;
                gnt_d    = '0;
            end
        endcase

        if (abort) begin
            state_d  = RECOVER;
            hs_req_d = 1'b0;
            gnt_d    = '0;
            err_d    = 1'b1;
            err_id_d = owner_q;
            ptr_d    = owner_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            wd_q     <= '0;
            hs_req_q <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
            warm_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            wd_q     <= wd_d;
            hs_req_q <= hs_req_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
            warm_q   <= {warm_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign hs_req   = hs_req_q;
    assign gnt_o    = gnt_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign err_id_o = err_id_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_hs4_channel_arbiter.sv
// Directed bench for hs4_channel_arbiter with a cycle-delay ack model.
// Table of arbitration vectors plus hand sequences for timeout, recovery, reset and drop.
module tb_hs4_channel_arbiter;

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic [3:0] done_o;
    logic       err_o;
    logic [1:0] err_id_o;
    logic       hs_req;
    logic       hs_ack;
    logic       busy_o;

    int checks;
    int failures;
    bit ack_auto;
    int ack_dly;
    int ack_cnt;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[16];

    hs4_channel_arbiter #(
        .N_REQ       (4),
        .SYNC_STAGES (2),
        .TIMEOUT     (10),
        .TO_W        (8)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .err_id_o (err_id_o),
        .hs_req   (hs_req),
        .hs_ack   (hs_ack),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    // Ack follows hs_req after ack_dly sampled cycles of disagreement.
    task automatic step();
        @(posedge clk);
        #1;
        if (ack_auto) begin
            if (hs_req !== hs_ack) begin
                ack_cnt++;
                if (ack_cnt >= ack_dly) begin
                    hs_ack  = hs_req;
                    ack_cnt = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(input string name, input int bound);
        int n = 0;
        while (gnt_o == 4'b0000 && n < bound) begin
            step();
            n++;
        end
        chk({name, "_gnt_seen"}, 32'(gnt_o != 4'b0000), 32'd1);
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (done_o == 4'b0000 && n < bound) begin
            step();
            n++;
        end
        chk({name, "_done_seen"}, 32'(done_o != 4'b0000), 32'd1);
    endtask

    task automatic do_reset();
        nrst     = 1'b0;
        req_i    = 4'b0000;
        ack_auto = 1'b0;
        hs_ack   = 1'b0;
        ack_cnt  = 0;
        step();
        step();
        nrst = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        nrst     = 1'b0;
        req_i    = 4'b0000;
        hs_ack   = 1'b0;
        ack_auto = 1'b0;
        ack_dly  = 5;
        ack_cnt  = 0;
        checks   = 0;
        failures = 0;

        // Pointer walk from 0; expected winners computed by hand.
        tbl[0]  = '{1'b1, 4'b0001, 4'b0001};
        tbl[1]  = '{1'b0, 4'b0011, 4'b0010};
        tbl[2]  = '{1'b0, 4'b1001, 4'b1000};
        tbl[3]  = '{1'b0, 4'b0110, 4'b0010};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0100};
        tbl[5]  = '{1'b0, 4'b0101, 4'b0001};
        tbl[6]  = '{1'b0, 4'b1000, 4'b1000};
        tbl[7]  = '{1'b0, 4'b1010, 4'b0010};
        tbl[8]  = '{1'b1, 4'b1111, 4'b0001};
        tbl[9]  = '{1'b0, 4'b1111, 4'b0010};
        tbl[10] = '{1'b0, 4'b1111, 4'b0100};
        tbl[11] = '{1'b0, 4'b1111, 4'b1000};
        tbl[12] = '{1'b0, 4'b1111, 4'b0001};
        tbl[13] = '{1'b0, 4'b1111, 4'b0010};
        tbl[14] = '{1'b0, 4'b1111, 4'b0100};
        tbl[15] = '{1'b0, 4'b1111, 4'b1000};

        step();
        step();
        chk("rst_gnt",    32'(gnt_o),    32'h0);
        chk("rst_hsreq",  32'(hs_req),   32'h0);
        chk("rst_done",   32'(done_o),   32'h0);
        chk("rst_err",    32'(err_o),    32'h0);
        chk("rst_err_id", 32'(err_id_o), 32'h0);
        chk("rst_busy",   32'(busy_o),   32'h0);
        nrst = 1'b1;
        repeat (4) step();

        // Single request, 5-cycle ack delay on each edge.
        ack_auto = 1'b1;
        ack_dly  = 5;
        req_i    = 4'b0001;
        step();
        chk("single_gnt",   32'(gnt_o),  32'h1);
        chk("single_hsreq", 32'(hs_req), 32'h1);
        chk("single_busy",  32'(busy_o), 32'h1);
        begin
            int n = 0;
            while (!hs_ack && n < 20) begin
                step();
                n++;
            end
        end
        chk("single_ack_rose", 32'(hs_ack), 32'h1);
        step();
        step();
        chk("single_hsreq_held_sync", 32'(hs_req), 32'h1);
        step();
        chk("single_hsreq_fall", 32'(hs_req), 32'h0);
        wait_done("single", 30);
        chk("single_done",      32'(done_o), 32'h1);
        chk("single_gnt_clear", 32'(gnt_o),  32'h0);
        req_i = 4'b0000;
        step();
        chk("single_done_width", 32'(done_o), 32'h0);
        req_i = 4'b0011;
        step();
        chk("single_ptr_is_1", 32'(gnt_o), 32'h2);
        wait_done("single_ptr", 30);
        req_i = 4'b0000;
        step();

        // Table: arbitration vectors and held 1111 round robin.
        ack_dly = 2;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst) begin
                do_reset();
                ack_auto = 1'b1;
            end
            req_i = tbl[i].req;
            wait_gnt("tbl", 30);
            chk($sformatf("tbl%0d_gnt", i),    32'(gnt_o), 32'(tbl[i].exp));
            chk($sformatf("tbl%0d_onehot", i), 32'($countones(gnt_o)), 32'd1);
            wait_done("tbl", 40);
            chk($sformatf("tbl%0d_done", i),   32'(done_o), 32'(tbl[i].exp));
            step();
            chk($sformatf("tbl%0d_done_width", i), 32'(done_o), 32'h0);
        end

        // Timeout: ack never rises.
        do_reset();
        req_i = 4'b0100;
        step();
        chk("to_gnt", 32'(gnt_o), 32'h4);
        for (int k = 1; k < 10; k++) begin
            step();
            chk($sformatf("to_no_err_c%0d", k), 32'({err_o, done_o}), 32'h0);
        end
        step();
        chk("to_err",       32'(err_o),    32'h1);
        chk("to_err_id",    32'(err_id_o), 32'h2);
        chk("to_hsreq_low", 32'(hs_req),   32'h0);
        chk("to_gnt_clear", 32'(gnt_o),    32'h0);
        chk("to_no_done",   32'(done_o),   32'h0);
        req_i = 4'b0000;
        step();
        chk("to_err_once", 32'(err_o), 32'h0);
        req_i = 4'b0001;
        wait_gnt("to_next", 10);
        chk("to_next_gnt", 32'(gnt_o), 32'h1);
        ack_auto = 1'b1;
        wait_done("to_next", 40);
        chk("to_next_done", 32'(done_o), 32'h1);
        req_i = 4'b0000;
        step();

        // Late ack: ack_s rises just as the abort lands, so RECOVER must wait.
        ack_auto = 1'b0;
        hs_ack   = 1'b0;
        req_i    = 4'b0001;
        step();
        chk("late_gnt", 32'(gnt_o), 32'h1);
        for (int k = 1; k < 10; k++) begin
            step();
            if (k == 8) hs_ack = 1'b1;
        end
        step();
        chk("late_err",    32'(err_o),    32'h1);
        chk("late_err_id", 32'(err_id_o), 32'h0);
        req_i = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("late_hold_c%0d", k), 32'({gnt_o, hs_req, err_o}), 32'h0);
            chk($sformatf("late_busy_c%0d", k), 32'(busy_o), 32'h1);
        end
        hs_ack = 1'b0;
        wait_gnt("late", 10);
        chk("late_gnt_after", 32'(gnt_o), 32'h2);
        ack_auto = 1'b1;
        wait_done("late", 40);
        chk("late_done", 32'(done_o), 32'h2);
        req_i = 4'b0000;
        step();

        // Reset during REQ_HI with ack held high.
        ack_auto = 1'b0;
        hs_ack   = 1'b0;
        req_i    = 4'b0001;
        step();
        chk("rmid_gnt", 32'(gnt_o), 32'h1);
        hs_ack = 1'b1;
        step();
        nrst = 1'b0;
        step();
        chk("rmid_outputs_zero", 32'({gnt_o, done_o, hs_req, err_o, err_id_o, busy_o}), 32'h0);
        step();
        nrst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("rmid_no_req_c%0d", k), 32'({gnt_o, hs_req}), 32'h0);
        end
        hs_ack = 1'b0;
        wait_gnt("rmid", 10);
        chk("rmid_gnt_after", 32'(gnt_o),  32'h1);
        chk("rmid_hsreq",     32'(hs_req), 32'h1);
        ack_auto = 1'b1;
        wait_done("rmid", 40);
        req_i = 4'b0000;
        step();

        // Request dropped while in REQ_LO.
        do_reset();
        ack_auto = 1'b1;
        ack_dly  = 3;
        req_i    = 4'b0100;
        wait_gnt("drop", 10);
        chk("drop_gnt", 32'(gnt_o), 32'h4);
        begin
            int n = 0;
            while (hs_req && n < 30) begin
                step();
                n++;
            end
        end
        chk("drop_in_reqlo", 32'({hs_req, busy_o}), 32'h1);
        req_i = 4'b0000;
        wait_done("drop", 30);
        chk("drop_done", 32'(done_o), 32'h4);
        step();
        chk("drop_done_width", 32'(done_o), 32'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("drop_no_regrant_c%0d", k), 32'(gnt_o), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
